// File: rtl/writeback_stage.sv
// WB stage of the 5-stage RISC-V pipeline: MEM/WB register, result select,
// load extension/alignment, register-file write port and retired-instruction counter.
module writeback_stage #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic                 wb_stall,
  input  logic                 flush,
  input  logic                 mem_reg_write,
  input  logic [4:0]           mem_rd,
  input  logic [1:0]           mem_wb_sel,
  input  logic [31:0]          mem_alu_result,
  input  logic [31:0]          mem_load_data,
  input  logic [2:0]           mem_load_funct3,
  input  logic [1:0]           mem_addr_lo,
  input  logic [31:0]          mem_pc_plus4,
  input  logic [31:0]          mem_imm,
  output logic                 write,
  output logic [4:0]           write_address,
  output logic [31:0]          write_data,
  output logic [CNT_WIDTH-1:0] retire_count
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic        vld_p0;
  logic        reg_write_p0;
  logic [4:0]  rd_p0;
  logic [1:0]  sel_p0;
  logic [31:0] alu_p0;
  logic [31:0] load_p0;
  logic [2:0]  funct3_p0;
  logic [1:0]  addr_lo_p0;
  logic [31:0] pc4_p0;
  logic [31:0] imm_p0;
  logic [31:0] result;
  logic        retire;

  // Picks the addressed byte/halfword out of the aligned word and extends it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lo);
    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        res;
    shifted = word >> {lo, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = 32'(byte_s);
      3'b100:  res = {24'd0, byte_s};
      3'b001:  res = 32'(half_s);
      3'b101:  res = {16'd0, half_s};
      default: res = word;
    endcase
    return res;
  endfunction

  // MEM -> WB register capture: stall holds everything, flush only drops valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p0       <= 1'b0;
      reg_write_p0 <= 1'b0;
      rd_p0        <= 5'd0;
      sel_p0       <= 2'b00;
      alu_p0       <= 32'd0;
      load_p0      <= 32'd0;
      funct3_p0    <= 3'd0;
      addr_lo_p0   <= 2'd0;
      pc4_p0       <= 32'd0;
      imm_p0       <= 32'd0;
    end else if (!wb_stall) begin
      vld_p0       <= mem_valid & ~flush;
      reg_write_p0 <= mem_reg_write;
      rd_p0        <= mem_rd;
      sel_p0       <= mem_wb_sel;
      alu_p0       <= mem_alu_result;
      load_p0      <= mem_load_data;
      funct3_p0    <= mem_load_funct3;
      addr_lo_p0   <= mem_addr_lo;
      pc4_p0       <= mem_pc_plus4;
      imm_p0       <= mem_imm;
    end
  end

  assign retire = vld_p0 & ~wb_stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retire_count <= '0;
    end else if (retire) begin
      retire_count <= retire_count + CNT_WIDTH'(1);
    end
  end

  // WB stage output: result select and register-file write port
  always_comb begin
    case (sel_p0)
      SEL_ALU:  result = alu_p0;
      SEL_LOAD: result = extend_load(load_p0, funct3_p0, addr_lo_p0);
      SEL_PC4:  result = pc4_p0;
      default:  result = imm_p0;
    endcase
  end

  assign mem_ready     = ~wb_stall;
  assign write         = retire & reg_write_p0 & (rd_p0 != 5'd0);
  assign write_address = vld_p0 ? rd_p0 : 5'd0;
  assign write_data    = vld_p0 ? result : 32'd0;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected writes are queued at issue time
// and popped when the entry sits live in WB; retire counter uses a 4-bit instance.
module tb_writeback_stage;

  localparam int CW = 4;

  logic          clock;
  logic          reset;
  logic          mem_valid;
  logic          mem_ready;
  logic          wb_stall;
  logic          flush;
  logic          mem_reg_write;
  logic [4:0]    mem_rd;
  logic [1:0]    mem_wb_sel;
  logic [31:0]   mem_alu_result;
  logic [31:0]   mem_load_data;
  logic [2:0]    mem_load_funct3;
  logic [1:0]    mem_addr_lo;
  logic [31:0]   mem_pc_plus4;
  logic [31:0]   mem_imm;
  logic          write;
  logic [4:0]    write_address;
  logic [31:0]   write_data;
  logic [CW-1:0] retire_count;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [CW-1:0] exp_count;
  int            tests;
  int            fails;

  writeback_stage #(.CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .flush(flush), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_load_funct3(mem_load_funct3),
    .mem_addr_lo(mem_addr_lo), .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm),
    .write(write), .write_address(write_address), .write_data(write_data),
    .retire_count(retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present one MEM instruction; the selected source carries val, the rest is noise.
  task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] val, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] expd);
    mem_valid       = 1'b1;
    mem_reg_write   = rw;
    mem_rd          = rd;
    mem_wb_sel      = sel;
    mem_load_funct3 = f3;
    mem_addr_lo     = lo;
    mem_alu_result  = $urandom;
    mem_load_data   = $urandom;
    mem_pc_plus4    = $urandom;
    mem_imm         = $urandom;
    case (sel)
      2'b00:   mem_alu_result = val;
      2'b01:   mem_load_data  = val;
      2'b10:   mem_pc_plus4   = val;
      default: mem_imm        = val;
    endcase
    sb.push_back('{we: rw && (rd != 5'd0), a: rd, d: expd});
  endtask

  task automatic test_reset;
    tests++;
    if ({write, write_address, write_data} !== 38'd0 || retire_count !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: we=%b a=%0d d=%h cnt=%0d, want all 0",
               write, write_address, write_data, retire_count);
    end
    tests++;
    if (mem_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_in_reset: got %b want 1", mem_ready);
    end
    wb_stall = 1'b1;
    #1;
    tests++;
    if (mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_stalled: got %b want 0", mem_ready);
    end
    wb_stall = 1'b0;
  endtask

  task automatic test_alu;
    issue(1'b1, 5'd5, 2'b00, 32'h0000_1234, 3'd0, 2'd0, 32'h0000_1234);
    @(negedge clock);
    mem_valid = 1'b0;
    e = sb.pop_front();
    tests++;
    if (write !== e.we || write_address !== e.a || write_data !== e.d) begin
      fails++;
      $display("FAIL alu_write: we=%b a=%0d d=%h want we=%b a=%0d d=%h",
               write, write_address, write_data, e.we, e.a, e.d);
    end
    exp_count++;
    @(negedge clock);
    tests++;
    if (write !== 1'b0 || retire_count !== exp_count) begin
      fails++;
      $display("FAIL alu_pulse: we=%b cnt=%0d want we=0 cnt=%0d", write, retire_count, exp_count);
    end
  endtask

  task automatic test_back_to_back_loads;
    logic [2:0]  f3 [7];
    logic [1:0]  lo [7];
    logic [31:0] ex [7];
    f3 = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b111};
    lo = '{2'd3,   2'd3,   2'd2,   2'd0,   2'd0,   2'd3,   2'd1};
    ex = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
           32'h80FF_7F01, 32'hFFFF_80FF, 32'h80FF_7F01};
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, 5'(10 + i), 2'b01, 32'h80FF_7F01, f3[i], lo[i], ex[i]);
      @(negedge clock);
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL load_sb: scoreboard empty");
      end else begin
        e = sb.pop_front();
        tests++;
        if (write !== e.we || write_address !== e.a || write_data !== e.d ||
            retire_count !== exp_count) begin
          fails++;
          $display("FAIL load_%0d: we=%b a=%0d d=%h cnt=%0d want we=%b a=%0d d=%h cnt=%0d",
                   i, write, write_address, write_data, retire_count, e.we, e.a, e.d, exp_count);
        end
        exp_count++;
      end
    end
    mem_valid = 1'b0;
    @(negedge clock);
    tests++;
    if (write !== 1'b0 || write_address !== 5'd0 || write_data !== 32'd0 ||
        retire_count !== exp_count) begin
      fails++;
      $display("FAIL load_drain: we=%b a=%0d d=%h cnt=%0d want 0/0/0/%0d",
               write, write_address, write_data, retire_count, exp_count);
    end
  endtask

  task automatic test_x0;
    issue(1'b1, 5'd0, 2'b11, 32'hDEAD_B000, 3'd0, 2'd0, 32'hDEAD_B000);
    @(negedge clock);
    mem_valid = 1'b0;
    e = sb.pop_front();
    tests++;
    if (write !== e.we || write_address !== e.a || write_data !== e.d) begin
      fails++;
      $display("FAIL x0_suppress: we=%b a=%0d d=%h want we=%b a=%0d d=%h",
               write, write_address, write_data, e.we, e.a, e.d);
    end
    exp_count++;
    @(negedge clock);
    tests++;
    if (retire_count !== exp_count) begin
      fails++;
      $display("FAIL x0_retire: cnt=%0d want %0d", retire_count, exp_count);
    end
  endtask

  task automatic test_stall_flush;
    issue(1'b1, 5'd7, 2'b10, 32'h0000_0104, 3'd0, 2'd0, 32'h0000_0104);
    @(negedge clock);
    wb_stall = 1'b1;
    issue(1'b1, 5'd9, 2'b00, 32'h0BAD_0BAD, 3'd0, 2'd0, 32'h0BAD_0BAD);
    void'(sb.pop_back());
    for (int c = 0; c < 3; c++) begin
      flush = (c == 1);
      #1;
      tests++;
      if (write !== 1'b0 || retire_count !== exp_count) begin
        fails++;
        $display("FAIL stall_cycle%0d: we=%b cnt=%0d want we=0 cnt=%0d",
                 c, write, retire_count, exp_count);
      end
      @(negedge clock);
    end
    wb_stall  = 1'b0;
    flush     = 1'b0;
    mem_valid = 1'b0;
    #1;
    e = sb.pop_front();
    tests++;
    if (write !== e.we || write_address !== e.a || write_data !== e.d ||
        retire_count !== exp_count) begin
      fails++;
      $display("FAIL stall_release: we=%b a=%0d d=%h cnt=%0d want we=%b a=%0d d=%h cnt=%0d",
               write, write_address, write_data, retire_count, e.we, e.a, e.d, exp_count);
    end
    exp_count++;
    @(negedge clock);
    tests++;
    if (write !== 1'b0 || retire_count !== exp_count) begin
      fails++;
      $display("FAIL stall_after: we=%b cnt=%0d want we=0 cnt=%0d", write, retire_count, exp_count);
    end
  endtask

  task automatic test_flush;
    issue(1'b1, 5'd3, 2'b00, 32'h0000_0055, 3'd0, 2'd0, 32'h0000_0055);
    @(negedge clock);
    issue(1'b1, 5'd4, 2'b00, 32'h0000_0066, 3'd0, 2'd0, 32'h0000_0066);
    void'(sb.pop_back());
    flush = 1'b1;
    e = sb.pop_front();
    tests++;
    if (write !== e.we || write_address !== e.a || write_data !== e.d) begin
      fails++;
      $display("FAIL flush_live_entry: we=%b a=%0d d=%h want we=%b a=%0d d=%h",
               write, write_address, write_data, e.we, e.a, e.d);
    end
    exp_count++;
    @(negedge clock);
    flush     = 1'b0;
    mem_valid = 1'b0;
    tests++;
    if (write !== 1'b0 || write_address !== 5'd0 || retire_count !== exp_count) begin
      fails++;
      $display("FAIL flush_dropped: we=%b a=%0d cnt=%0d want 0/0/%0d",
               write, write_address, retire_count, exp_count);
    end
  endtask

  task automatic test_midreset;
    issue(1'b1, 5'd6, 2'b00, 32'h0000_0666, 3'd0, 2'd0, 32'h0000_0666);
    @(negedge clock);
    mem_valid = 1'b0;
    e = sb.pop_front();
    tests++;
    if (write !== e.we || write_address !== e.a || write_data !== e.d) begin
      fails++;
      $display("FAIL midreset_live: we=%b a=%0d d=%h want we=%b a=%0d d=%h",
               write, write_address, write_data, e.we, e.a, e.d);
    end
    #2 reset = 1'b0;
    #1;
    exp_count = '0;
    tests++;
    if (write !== 1'b0 || write_address !== 5'd0 || write_data !== 32'd0 ||
        retire_count !== exp_count || mem_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_async: we=%b a=%0d d=%h cnt=%0d rdy=%b want 0/0/0/0/1",
               write, write_address, write_data, retire_count, mem_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (write !== 1'b0 || retire_count !== exp_count) begin
      fails++;
      $display("FAIL midreset_after: we=%b cnt=%0d want 0/0", write, retire_count);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 17; i++) begin
      issue(1'b1, 5'(1 + i), 2'b00, 32'(i * 3), 3'd0, 2'd0, 32'(i * 3));
      @(negedge clock);
      e = sb.pop_front();
      tests++;
      if (write !== e.we || write_address !== e.a || write_data !== e.d ||
          retire_count !== exp_count) begin
        fails++;
        $display("FAIL wrap_%0d: we=%b a=%0d d=%h cnt=%0d want we=%b a=%0d d=%h cnt=%0d",
                 i, write, write_address, write_data, retire_count, e.we, e.a, e.d, exp_count);
      end
      exp_count++;
    end
    mem_valid = 1'b0;
    @(negedge clock);
    tests++;
    if (retire_count !== 4'd1) begin
      fails++;
      $display("FAIL wrap_final: cnt=%0d want 1", retire_count);
    end
  endtask

  initial begin
    tests = 0; fails = 0; exp_count = '0;
    reset = 1'b0; mem_valid = 1'b0; wb_stall = 1'b0; flush = 1'b0;
    mem_reg_write = 1'b0; mem_rd = 5'd0; mem_wb_sel = 2'b00;
    mem_alu_result = 32'd0; mem_load_data = 32'd0; mem_load_funct3 = 3'd0;
    mem_addr_lo = 2'd0; mem_pc_plus4 = 32'd0; mem_imm = 32'd0;
    #2;
    test_reset;
    @(negedge clock);
    reset = 1'b1;
    test_alu;
    test_back_to_back_loads;
    test_x0;
    test_stall_flush;
    test_flush;
    test_midreset;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
